adc_remap_tbl: RTL

Parametrised, table-driven successor to the fixed 32×16-bit ADC channel remapper in the FIR control path. Each output lane is sourced from any input channel through a programmable lookup table, or is forced to zero by a per-lane mask. Identity and reverse modes are kept as fast presets. Table, mode and mask are written into a shadow copy and swapped into the active copy only at a frame start, so a frame is never remapped with a mixed configuration. The block sits between the ADC capture/alignment stage and the FIR filter bank, carrying the encoder header alongside the data.

---
 rtl/adc_remap_tbl_if.sv | 38 +++
 rtl/adc_remap_tbl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adc_remap_tbl_if.sv
// Bundle of configuration and beat signals for the ADC channel remapper.
// The master side drives configuration and input beats; the slave side is the remapper.
interface adc_remap_tbl_if #(
   parameter int CH_NUM  = 32,
   parameter int CH_WD   = 16,
   parameter int HEAD_WD = 64,
   parameter int IDX_WD  = 5
);
   logic                      cfg_rst;
   logic                      cfg_wr_en;
   logic [IDX_WD-1:0]         cfg_wr_addr;
   logic [IDX_WD-1:0]         cfg_wr_src;
   logic [1:0]                cfg_mode;
   logic [CH_NUM-1:0]         cfg_mask;
   logic                      cfg_commit;
   logic                      cfg_pending;

   logic                      map_ivld;
   logic                      map_isof;
   logic [CH_NUM*CH_WD-1:0]   map_idat;
   logic [HEAD_WD-1:0]        enc_idat;
   logic                      map_ovld;
   logic                      map_osof;
   logic [CH_NUM*CH_WD-1:0]   map_odat;
   logic [HEAD_WD-1:0]        enc_odat;

   modport master (
      output cfg_rst, cfg_wr_en, cfg_wr_addr, cfg_wr_src, cfg_mode, cfg_mask, cfg_commit,
      output map_ivld, map_isof, map_idat, enc_idat,
      input  cfg_pending, map_ovld, map_osof, map_odat, enc_odat
   );

   modport slave (
      input  cfg_rst, cfg_wr_en, cfg_wr_addr, cfg_wr_src, cfg_mode, cfg_mask, cfg_commit,
      input  map_ivld, map_isof, map_idat, enc_idat,
      output cfg_pending, map_ovld, map_osof, map_odat, enc_odat
   );
endinterface

// File: rtl/adc_remap_tbl.sv
// Table-driven ADC channel remapper with shadow/active configuration.
// Configuration is written into a shadow copy and becomes active only on a
// frame-start beat, so one frame never mixes two configurations.
// Two-stage pipeline: stage 1 captures the beat plus its resolved per-lane
// source select, stage 2 applies the mux and mask.
module adc_remap_tbl #(
   parameter int CH_NUM  = 32,
   parameter int CH_WD   = 16,
   parameter int HEAD_WD = 64,
   parameter int IDX_WD  = 5
) (
   input logic              clk,
   input logic              rst_n,
   adc_remap_tbl_if.slave   bus
);

   localparam logic [IDX_WD:0] CH_NUM_W   = (IDX_WD+1)'(CH_NUM);
   localparam logic [1:0]      MODE_IDENT = 2'd0;
   localparam logic [1:0]      MODE_REV   = 2'd1;
   localparam int              DW         = CH_NUM*CH_WD;

   typedef logic [IDX_WD-1:0] idx_t;

   idx_t                tbl_s     [CH_NUM];
   idx_t                tbl_a     [CH_NUM];
   idx_t                tbl_s_nxt [CH_NUM];
   idx_t                eff_tbl   [CH_NUM];
   logic [1:0]          mode_s, mode_a, mode_s_nxt, eff_mode;
   logic [CH_NUM-1:0]   mask_s, mask_a, mask_s_nxt, eff_mask;
   logic                pending;
   logic                swap;
   logic                wr_ok;

   idx_t                lane_sel  [CH_NUM];
   logic [CH_NUM-1:0]   lane_zero;

   logic                s1_vld, s1_sof;
   logic [DW-1:0]       s1_dat;
   logic [HEAD_WD-1:0]  s1_hdr;
   idx_t                s1_sel    [CH_NUM];
   logic [CH_NUM-1:0]   s1_zero;
   logic [CH_WD-1:0]    s1_ch     [CH_NUM];
   logic [DW-1:0]       mux_dat;

   logic                s2_vld, s2_sof;
   logic [DW-1:0]       s2_dat;
   logic [HEAD_WD-1:0]  s2_hdr;

   // Shadow copy as it will look after this edge, and whether this beat swaps it in.
   always_comb begin
      wr_ok = bus.cfg_wr_en & ({1'b0, bus.cfg_wr_addr} < CH_NUM_W);
      for (int j = 0; j < CH_NUM; j++) begin
         tbl_s_nxt[j] = tbl_s[j];
         if (wr_ok && (bus.cfg_wr_addr == idx_t'(j)))
            tbl_s_nxt[j] = bus.cfg_wr_src;
      end
      mode_s_nxt = bus.cfg_commit ? bus.cfg_mode : mode_s;
      mask_s_nxt = bus.cfg_commit ? bus.cfg_mask : mask_s;
      // A commit landing on the SOF beat itself still swaps on that beat.
      swap = bus.map_ivld & bus.map_isof & (pending | bus.cfg_commit);
   end

   // Configuration seen by the beat captured on this edge; also the next active copy.
   always_comb begin
      eff_mode = mode_a;
      eff_mask = mask_a;
      for (int j = 0; j < CH_NUM; j++)
         eff_tbl[j] = tbl_a[j];
      if (bus.cfg_rst) begin
         eff_mode = MODE_IDENT;
         eff_mask = '0;
         for (int j = 0; j < CH_NUM; j++)
            eff_tbl[j] = idx_t'(j);
      end else if (swap) begin
         eff_mode = mode_s_nxt;
         eff_mask = mask_s_nxt;
         for (int j = 0; j < CH_NUM; j++)
            eff_tbl[j] = tbl_s_nxt[j];
      end
   end

   // Per-lane source channel and zero flag from the effective configuration.
   always_comb begin
      for (int j = 0; j < CH_NUM; j++) begin
         lane_sel[j]  = idx_t'(j);
         lane_zero[j] = eff_mask[j];
         if (eff_mode == MODE_REV) begin
            lane_sel[j] = idx_t'(CH_NUM-1-j);
         end else if (eff_mode[1]) begin
            lane_sel[j] = eff_tbl[j];
            if ({1'b0, eff_tbl[j]} >= CH_NUM_W)
               lane_zero[j] = 1'b1;
         end
      end
   end

   // Shadow/active configuration registers and the pending-commit flag.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.cfg_rst) begin
         for (int j = 0; j < CH_NUM; j++) begin
            tbl_s[j] <= idx_t'(j);
            tbl_a[j] <= idx_t'(j);
         end
         mode_s  <= MODE_IDENT;
         mode_a  <= MODE_IDENT;
         mask_s  <= '0;
         mask_a  <= '0;
         pending <= 1'b0;
      end else begin
         for (int j = 0; j < CH_NUM; j++) begin
            tbl_s[j] <= tbl_s_nxt[j];
            tbl_a[j] <= eff_tbl[j];
         end
         mode_s  <= mode_s_nxt;
         mask_s  <= mask_s_nxt;
         mode_a  <= eff_mode;
         mask_a  <= eff_mask;
         pending <= ~swap & (pending | bus.cfg_commit);
      end
   end

   // Stage 1: capture the beat together with its resolved lane selects.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_sof  <= 1'b0;
         s1_dat  <= '0;
         s1_hdr  <= '0;
         s1_zero <= '0;
         for (int j = 0; j < CH_NUM; j++)
            s1_sel[j] <= '0;
      end else begin
         s1_vld <= bus.map_ivld;
         s1_sof <= bus.map_ivld & bus.map_isof;
         if (bus.map_ivld) begin
            s1_dat  <= bus.map_idat;
            s1_hdr  <= bus.enc_idat;
            s1_zero <= lane_zero;
            for (int j = 0; j < CH_NUM; j++)
               s1_sel[j] <= lane_sel[j];
         end
      end
   end

   // Split the captured beat into channels for the lane mux.
   always_comb begin
      for (int i = 0; i < CH_NUM; i++)
         s1_ch[i] = s1_dat[i*CH_WD +: CH_WD];
   end

   // Lane mux with zero forcing.
   always_comb begin
      mux_dat = '0;
      for (int j = 0; j < CH_NUM; j++) begin
         if (!s1_zero[j])
            mux_dat[j*CH_WD +: CH_WD] = s1_ch[s1_sel[j]];
      end
   end

   // Stage 2: output register; data and header hold between valid beats.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_vld <= 1'b0;
         s2_sof <= 1'b0;
         s2_dat <= '0;
         s2_hdr <= '0;
      end else begin
         s2_vld <= s1_vld;
         s2_sof <= s1_sof;
         if (s1_vld) begin
            s2_dat <= mux_dat;
            s2_hdr <= s1_hdr;
         end
      end
   end

   assign bus.cfg_pending = pending;
   assign bus.map_ovld    = s2_vld;
   assign bus.map_osof    = s2_sof;
   assign bus.map_odat    = s2_dat;
   assign bus.enc_odat    = s2_hdr;

endmodule
